bram_port_arbiter: RTL and testbench

Parametrised, registered owner-switching multiplexer for one simple-dual-port BRAM (one write port, one read port) shared by NCH phase engines of the Kyber512 datapath. Ownership is granted one channel at a time from a select input driven by the top-level controller. A switch of owner drains in-flight reads before the next owner is granted. Read data is returned with a per-channel valid strobe aligned to BRAM read latency.

---
 rtl/bram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Registered owner-switching mux that shares one simple-dual-port BRAM among NCH clients.
// Define BRAM_MUX_WR_FWD_EN for write-first forwarding on same-cycle read/write address hits.
module bram_port_arbiter #(
  parameter int NCH    = 4,
  parameter int DW     = 128,
  parameter int AW     = 8,
  parameter int RD_LAT = 1,
  localparam int SW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW-1:0]     sel,
  input  logic              sel_vld,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_waddr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_ren,
  input  logic [NCH*AW-1:0] ch_raddr,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [DW-1:0]     ch_rdata,
  output logic              bram_wen,
  output logic [AW-1:0]     bram_waddr,
  output logic [DW-1:0]     bram_wdata,
  output logic              bram_ren,
  output logic [AW-1:0]     bram_raddr,
  input  logic [DW-1:0]     bram_rdata,
  output logic              busy,
  output logic              err_unowned
);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [SW-1:0]           owner, owner_nx;
  logic [NCH-1:0]          gnt_nx;
  logic [CW-1:0]           cnt;
  logic                    acc_w, acc_r;
  logic [AW-1:0]           wa, ra;
  logic [DW-1:0]           wd, ret_data;
  logic [RD_LAT:0]         vld_pipe;
  logic [RD_LAT:0][SW-1:0] tag_pipe;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      IDLE:  if (sel_vld) begin state_nx = OWN; owner_nx = sel; end
      OWN:   if (!sel_vld || sel != owner) state_nx = DRAIN;
      DRAIN: if (cnt == '0) begin
        if (sel_vld) begin state_nx = OWN; owner_nx = sel; end
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    gnt_nx = '0;
    for (int c = 0; c < NCH; c++)
      if (state_nx == OWN && owner_nx == SW'(c)) gnt_nx[c] = 1'b1;
  end

  // ch_gnt is one-hot, so an OR-reduction acts as the owner mux
  always_comb begin
    acc_w = |(ch_wen & ch_gnt);
    acc_r = |(ch_ren & ch_gnt);
    wa = '0;
    wd = '0;
    ra = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_gnt[c]) begin
        wa |= ch_waddr[c*AW +: AW];
        wd |= ch_wdata[c*DW +: DW];
        ra |= ch_raddr[c*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ch_gnt      <= '0;
      bram_wen    <= 1'b0;
      bram_waddr  <= '0;
      bram_wdata  <= '0;
      bram_ren    <= 1'b0;
      bram_raddr  <= '0;
      err_unowned <= 1'b0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      ch_gnt      <= gnt_nx;
      bram_wen    <= acc_w;
      bram_waddr  <= acc_w ? wa : '0;
      bram_wdata  <= acc_w ? wd : '0;
      bram_ren    <= acc_r;
      bram_raddr  <= acc_r ? ra : '0;
      err_unowned <= err_unowned | (|((ch_wen | ch_ren) & ~ch_gnt));
      vld_pipe    <= {vld_pipe[RD_LAT-1:0], acc_r};
      tag_pipe    <= {tag_pipe[RD_LAT-1:0], (acc_r ? owner : {SW{1'b0}})};
    end
  end

  // Only reads whose data is still two or more cycles out block the drain exit,
  // which makes a last-cycle read hold DRAIN for exactly RD_LAT cycles.
  generate
    if (RD_LAT > 1) begin : g_cnt
      logic inc, dec;
      assign inc = acc_r;
      assign dec = vld_pipe[RD_LAT-2];
      always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (inc && !dec && cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
      end
    end else begin : g_nocnt
      assign cnt = '0;
    end
  endgenerate

`ifdef BRAM_MUX_WR_FWD_EN
  logic                    hit;
  logic [RD_LAT:0]         fwd_pipe;
  logic [RD_LAT:0][DW-1:0] fdat_pipe;
  assign hit = acc_r && acc_w && (wa == ra);
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_pipe  <= '0;
      fdat_pipe <= '0;
    end else begin
      fwd_pipe  <= {fwd_pipe[RD_LAT-1:0], hit};
      fdat_pipe <= {fdat_pipe[RD_LAT-1:0], (hit ? wd : {DW{1'b0}})};
    end
  end
  assign ret_data = fwd_pipe[RD_LAT] ? fdat_pipe[RD_LAT] : bram_rdata;
`else
  assign ret_data = bram_rdata;
`endif

  always_comb begin
    ch_rvalid = '0;
    for (int c = 0; c < NCH; c++)
      if (vld_pipe[RD_LAT] && tag_pipe[RD_LAT] == SW'(c)) ch_rvalid[c] = 1'b1;
  end

  assign ch_rdata = vld_pipe[RD_LAT] ? ret_data : '0;
  assign busy     = (state == DRAIN) || (|vld_pipe);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model plus a queue-based ownership/return model checked every cycle.
module tb_bram_port_arbiter;
  localparam int NCH = 4, DW = 128, AW = 8, RD_LAT = 2, SW = 2;
`ifdef BRAM_MUX_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [DW-1:0] XW = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DW-1:0] R3 = 128'h3333_aaaa_5555_cccc_1111_2222_4444_8888;
  localparam logic [DW-1:0] OV = 128'h0a0a_0b0b_0c0c_0d0d_0e0e_0f0f_1010_1111;
  localparam logic [DW-1:0] DV = 128'hd0d0_d1d1_d2d2_d3d3_d4d4_d5d5_d6d6_d7d7;

  logic              clk = 1'b0;
  logic              rst;
  logic [SW-1:0]     sel;
  logic              sel_vld;
  logic [NCH-1:0]    ch_wen, ch_ren, ch_gnt, ch_rvalid;
  logic [NCH*AW-1:0] ch_waddr, ch_raddr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ch_rdata, bram_wdata, bram_rdata;
  logic              bram_wen, bram_ren, busy, err_unowned;
  logic [AW-1:0]     bram_waddr, bram_raddr;

  always #5 clk = ~clk;

  bram_port_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .sel(sel), .sel_vld(sel_vld),
    .ch_wen(ch_wen), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
    .ch_ren(ch_ren), .ch_raddr(ch_raddr),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .busy(busy), .err_unowned(err_unowned)
  );

  // read-first BRAM with RD_LAT cycles of read latency
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] rd_q [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bram_ren) rd_q[0] <= mem[bram_raddr];
    for (int k = 1; k < RD_LAT; k++) rd_q[k] <= rd_q[k-1];
    if (bram_wen) mem[bram_waddr] <= bram_wdata;
  end
  assign bram_rdata = rd_q[RD_LAT-1];

  typedef struct { int due; int ch; logic [DW-1:0] data; } ret_t;
  ret_t           rq[$];
  logic [DW-1:0]  m_mem [0:(1<<AW)-1];
  int             m_own, last_rd, cyc;
  bit             m_drain, m_err;
  logic [NCH-1:0] e_gnt;
  logic           e_wen, e_ren;
  logic [AW-1:0]  e_waddr, e_raddr;
  logic [DW-1:0]  e_wdata;
  int             n_cmp, n_bad;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic int granted();
    return (m_own >= 0 && !m_drain) ? m_own : -1;
  endfunction

  // Advance the model by the inputs of the current cycle.
  task automatic model_step();
    int g;
    bit aw, ar;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    ret_t r;
    if (rst) begin
      m_own = -1; m_drain = 0; m_err = 0; last_rd = -100; rq.delete();
      e_gnt = '0; e_wen = 0; e_ren = 0; e_waddr = '0; e_raddr = '0; e_wdata = '0;
      return;
    end
    g = granted();
    for (int c = 0; c < NCH; c++)
      if ((ch_wen[c] || ch_ren[c]) && c != g) m_err = 1;
    aw = 0; ar = 0; wa = '0; ra = '0; wd = '0;
    if (g >= 0) begin
      aw = ch_wen[g];
      ar = ch_ren[g];
      if (aw) begin wa = ch_waddr[g*AW +: AW]; wd = ch_wdata[g*DW +: DW]; end
      if (ar) ra = ch_raddr[g*AW +: AW];
    end
    if (ar) begin
      r.due = cyc + 1 + RD_LAT;
      r.ch = g;
      r.data = (FWD && aw && wa == ra) ? wd : m_mem[ra];
      rq.push_back(r);
      last_rd = cyc;
    end
    if (aw) m_mem[wa] = wd;
    e_wen = aw; e_waddr = wa; e_wdata = wd; e_ren = ar; e_raddr = ra;
    if (g >= 0) begin
      if (!sel_vld || int'(sel) != m_own) m_drain = 1;
    end else if (m_drain) begin
      if (cyc - last_rd >= RD_LAT) begin
        m_drain = 0;
        m_own = sel_vld ? int'(sel) : -1;
      end
    end else if (sel_vld) begin
      m_own = int'(sel);
    end
    e_gnt = '0;
    if (granted() >= 0) e_gnt[granted()] = 1'b1;
  endtask

  task automatic check_all();
    logic [NCH-1:0] xv;
    logic [DW-1:0] xd;
    bit xb;
    xb = m_drain || rq.size() > 0;
    xv = '0;
    xd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      xv[rq[0].ch] = 1'b1;
      xd = rq[0].data;
      void'(rq.pop_front());
    end
    chk("ch_gnt", ch_gnt, e_gnt);
    chk("bram_wen", bram_wen, e_wen);
    chk("bram_waddr", bram_waddr, e_waddr);
    chk("bram_wdata", bram_wdata, e_wdata);
    chk("bram_ren", bram_ren, e_ren);
    chk("bram_raddr", bram_raddr, e_raddr);
    chk("ch_rvalid", ch_rvalid, xv);
    chk("ch_rdata", ch_rdata, xd);
    chk("busy", busy, xb);
    chk("err_unowned", err_unowned, m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic idle_in();
    ch_wen = '0; ch_ren = '0; ch_waddr = '0; ch_raddr = '0; ch_wdata = '0;
  endtask

  task automatic wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_wen[c] = 1'b1; ch_waddr[c*AW +: AW] = a; ch_wdata[c*DW +: DW] = d;
  endtask

  task automatic rd(input int c, input logic [AW-1:0] a);
    ch_ren[c] = 1'b1; ch_raddr[c*AW +: AW] = a;
  endtask

  initial begin
    int g;
    logic [DW-1:0] v;
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_own = -1; m_drain = 0; m_err = 0; last_rd = -100;
    for (int i = 0; i < (1<<AW); i++) begin
      v = rnd();
      mem[i] <= v;
      m_mem[i] = v;
    end
    for (int k = 0; k < RD_LAT; k++) rd_q[k] <= '0;
    rst = 1; sel = '0; sel_vld = 0; idle_in();
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_gnt", ch_gnt, 4'b0000);
    chk("rst_bram_wen", bram_wen, 1'b0);
    chk("rst_busy", busy, 1'b0);

    sel = 2'd2; sel_vld = 1;
    tick();
    chk("gnt_ch2", ch_gnt, 4'b0100);
    wr(2, 8'h15, XW);
    tick();
    chk("wr_wen", bram_wen, 1'b1);
    chk("wr_waddr", bram_waddr, 8'h15);
    chk("wr_wdata", bram_wdata, XW);
    idle_in();
    tick();
    chk("wr_waddr_zero", bram_waddr, 8'h00);
    chk("wr_wdata_zero", bram_wdata, '0);

    sel = 2'd1;
    tick();
    chk("drain_empty", ch_gnt, 4'b0000);
    tick();
    chk("gnt_ch1", ch_gnt, 4'b0010);
    wr(1, 8'h03, R3);
    tick();
    idle_in(); rd(1, 8'h03); sel = 2'd3;
    tick();
    chk("drain1_gnt", ch_gnt, 4'b0000);
    chk("drain1_raddr", bram_raddr, 8'h03);
    idle_in();
    tick();
    chk("drain2_gnt", ch_gnt, 4'b0000);
    chk("drain2_busy", busy, 1'b1);
    tick();
    chk("gnt_ch3", ch_gnt, 4'b1000);
    chk("ret_rvalid", ch_rvalid, 4'b0010);
    chk("ret_rdata", ch_rdata, R3);
    tick();
    chk("ret_once", ch_rvalid, 4'b0000);

    wr(3, 8'h40, OV);
    tick();
    idle_in(); wr(3, 8'h40, DV); rd(3, 8'h40);
    tick();
    idle_in();
    tick(); tick();
    chk("coll_rvalid", ch_rvalid, 4'b1000);
    chk("coll_rdata", ch_rdata, FWD ? DV : OV);

    sel = 2'd0;
    tick(); tick();
    chk("gnt_ch0", ch_gnt, 4'b0001);
    wr(3, 8'h77, XW);
    tick();
    chk("unowned_err", err_unowned, 1'b1);
    chk("unowned_nowr", bram_wen, 1'b0);
    idle_in();
    tick(); tick();
    chk("err_sticky", err_unowned, 1'b1);

    rd(0, 8'h40);
    tick();
    chk("pre_rst_ren", bram_ren, 1'b1);
    idle_in(); rst = 1;
    tick();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_gnt", ch_gnt, 4'b0000);
    chk("rst_mid_err", err_unowned, 1'b0);
    rst = 0; sel_vld = 0;
    tick();
    chk("rst_mid_norv", ch_rvalid, 4'b0000);

    for (int i = 0; i < 2000; i++) begin
      idle_in();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, NCH-1));
      if ($urandom_range(0, 15) == 0) sel_vld = ~sel_vld;
      g = granted();
      if (g >= 0) begin
        if ($urandom_range(0, 1) == 1) wr(g, AW'($urandom_range(0, 15)), rnd());
        if ($urandom_range(0, 1) == 1) rd(g, AW'($urandom_range(0, 15)));
      end
      if (i > 1500 && $urandom_range(0, 49) == 0) ch_ren[$urandom_range(0, NCH-1)] = 1'b1;
      tick();
    end
    rst = 0; idle_in(); sel_vld = 0;
    for (int i = 0; i < RD_LAT + 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
